// File: rtl/button_encoder_4to2.sv
// Registered 4-to-2 priority encoder for four active-low pushbuttons.
// Each raw button goes through a two-flop synchroniser and a counter-based
// debouncer. The highest-index pressed button is encoded and registered
// together with valid/multi flags and a one-cycle press strobe.
module button_encoder_4to2 #(
  parameter int unsigned DEBOUNCE_CYCLES = 12000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_n,
  output logic [1:0] code,
  output logic       valid,
  output logic       multi,
  output logic       press
);

  // Counter is just wide enough to reach DEBOUNCE_CYCLES-1.
  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_t;

  logic [3:0] s1_q;
  logic [3:0] s2_q;
  logic [3:0] deb;

  logic [1:0] code_d;
  logic       valid_d;
  logic       multi_d;
  logic       press_d;
  logic [2:0] ones;

  state_t     state_q;
  state_t     state_d;

  logic [1:0] code_q;
  logic       valid_q;
  logic       multi_q;
  logic       press_q;

  // Two-flop synchroniser; released (all ones) out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 4'hF;
      s2_q <= 4'hF;
    end else begin
      s1_q <= btn_n;
      s2_q <= s1_q;
    end
  end

  // One debouncer per button: a level change is accepted only after it has
  // been seen for DEBOUNCE_CYCLES consecutive cycles at the synchroniser.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_deb
      logic [CW-1:0] cnt_q;
      logic          deb_q;

      // Count consecutive disagreeing samples; toggle on the last one.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q <= '0;
          deb_q <= 1'b0;
        end else if (~s2_q[gi] == deb_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_MAX) begin
          deb_q <= ~deb_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end

      assign deb[gi] = deb_q;
    end
  endgenerate

  // Priority encode the debounced buttons; bit 3 wins.
  always_comb begin
    code_d  = 2'd0;
    ones    = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (deb[i]) begin
        code_d = 2'(i);
      end
      ones = ones + {2'b00, deb[i]};
    end
    valid_d = |deb;
    multi_d = (ones >= 3'd2);
  end

  // FSM next state and press decision: press on a new hold or when the
  // priority owner changes while held; never on release.
  always_comb begin
    state_d = state_q;
    press_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_d) begin
          state_d = HELD;
          press_d = 1'b1;
        end
      end
      HELD: begin
        if (!valid_d) begin
          state_d = IDLE;
        end else if (code_d != code_q) begin
          press_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      code_q  <= 2'd0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
      press_q <= press_d;
    end
  end

  assign code  = code_q;
  assign valid = valid_q;
  assign multi = multi_q;
  assign press = press_q;

endmodule

// File: tb/tb_button_encoder_4to2.sv
// Bench for button_encoder_4to2 with DEBOUNCE_CYCLES=4: a table of directed
// steps with fixed expected outputs, plus random bursts, all cross-checked
// every cycle against a sample-history reference model.
module tb_button_encoder_4to2;

  localparam int N = 4;

  logic       clk;
  logic       rst;
  logic [3:0] btn_n;
  logic [1:0] code;
  logic       valid;
  logic       multi;
  logic       press;

  button_encoder_4to2 #(.DEBOUNCE_CYCLES(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .btn_n (btn_n),
    .code  (code),
    .valid (valid),
    .multi (multi),
    .press (press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Reference model: raw pipeline delay, history of synchronised samples,
  // and output rules stated on the encoded values.
  logic [3:0] m_s1, m_s2, m_deb;
  logic [3:0] hist[$];
  int         since[4];
  logic [1:0] m_code;
  logic       m_valid, m_multi, m_press;

  task automatic model_edge(input logic r, input logic [3:0] b);
    logic [1:0] nc;
    logic       nv;
    logic       all_opp;
    if (r) begin
      m_s1 = 4'hF; m_s2 = 4'hF; m_deb = 4'h0;
      hist.delete();
      for (int i = 0; i < 4; i++) since[i] = 0;
      m_code = 2'd0; m_valid = 1'b0; m_multi = 1'b0; m_press = 1'b0;
    end else begin
      nv = (m_deb != 4'h0);
      nc = 2'd0;
      for (int i = 3; i >= 0; i--) begin
        if (m_deb[i]) begin
          nc = 2'(i);
          break;
        end
      end
      m_press = nv && (!m_valid || nc != m_code);
      m_code  = nc;
      m_valid = nv;
      m_multi = ($countones(m_deb) >= 2);
      hist.push_back(~m_s2);
      if (hist.size() > N) void'(hist.pop_front());
      for (int i = 0; i < 4; i++) begin
        if (since[i] < N) since[i]++;
        if (since[i] >= N) begin
          all_opp = 1'b1;
          for (int k = 0; k < N; k++)
            if (hist[k][i] == m_deb[i]) all_opp = 1'b0;
          if (all_opp) begin
            m_deb[i] = ~m_deb[i];
            since[i] = 0;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = b;
    end
  endtask

  task automatic apply(input logic r, input logic [3:0] b, input int n);
    for (int c = 0; c < n; c++) begin
      rst = r;
      btn_n = b;
      @(posedge clk);
      model_edge(r, b);
      #1;
      vectors++;
      if ({code, valid, multi, press} !== {m_code, m_valid, m_multi, m_press}) begin
        errors++;
        $display("FAIL model t=%0t btn_n=%b rst=%b: got code=%0d valid=%b multi=%b press=%b, want code=%0d valid=%b multi=%b press=%b",
                 $time, b, r, code, valid, multi, press, m_code, m_valid, m_multi, m_press);
      end
    end
  endtask

  typedef struct {
    string      name;
    logic       rst;
    logic [3:0] btn_n;
    int         cycles;
    logic [1:0] code;
    logic       valid;
    logic       multi;
    logic       press;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input string nm, input logic r, input logic [3:0] b, input int n,
                              input logic [1:0] c, input logic v, input logic m, input logic p);
    vec_t e;
    e.name = nm; e.rst = r; e.btn_n = b; e.cycles = n;
    e.code = c; e.valid = v; e.multi = m; e.press = p;
    tbl.push_back(e);
  endfunction

  initial begin
    logic [3:0] rb;
    logic       rr;
    int         rn;

    rst = 1'b1;
    btn_n = 4'hF;

    // Reset and single press/release.
    add("reset",        1, 4'b1111, 3, 2'd0, 0, 0, 0);
    add("p1_pre",       0, 4'b1101, 6, 2'd0, 0, 0, 0);
    add("p1_edge7",     0, 4'b1101, 1, 2'd1, 1, 0, 1);
    add("p1_edge8",     0, 4'b1101, 1, 2'd1, 1, 0, 0);
    add("r1_pre",       0, 4'b1111, 6, 2'd1, 1, 0, 0);
    add("r1_edge7",     0, 4'b1111, 1, 2'd0, 0, 0, 0);
    // Bounce rejection: five 3-cycle lows on button 2.
    for (int k = 0; k < 5; k++) begin
      add("bounce_lo",  0, 4'b1011, 3, 2'd0, 0, 0, 0);
      add("bounce_hi",  0, 4'b1111, 1, 2'd0, 0, 0, 0);
    end
    add("bounce_end",   0, 4'b1111, 4, 2'd0, 0, 0, 0);
    // Priority and multi.
    add("b0_press",     0, 4'b1110, 7, 2'd0, 1, 0, 1);
    add("b0_hold",      0, 4'b1110, 2, 2'd0, 1, 0, 0);
    add("b3_pre",       0, 4'b0110, 6, 2'd0, 1, 0, 0);
    add("b3_accept",    0, 4'b0110, 1, 2'd3, 1, 1, 1);
    add("b3_after",     0, 4'b0110, 1, 2'd3, 1, 1, 0);
    add("b3_rel_pre",   0, 4'b1110, 6, 2'd3, 1, 1, 0);
    add("b3_rel",       0, 4'b1110, 1, 2'd0, 1, 0, 1);
    add("b3_rel_after", 0, 4'b1110, 1, 2'd0, 1, 0, 0);
    add("all_rel",      0, 4'b1111, 7, 2'd0, 0, 0, 0);
    // Lower button added under a higher one.
    add("hi_press",     0, 4'b0111, 7, 2'd3, 1, 0, 1);
    add("hi_hold",      0, 4'b0111, 1, 2'd3, 1, 0, 0);
    add("lo_added",     0, 4'b0101, 7, 2'd3, 1, 1, 0);
    add("both_rel",     0, 4'b1111, 7, 2'd0, 0, 0, 0);
    // Simultaneous press.
    add("sim_pre",      0, 4'b0110, 6, 2'd0, 0, 0, 0);
    add("sim_edge7",    0, 4'b0110, 1, 2'd3, 1, 1, 1);
    add("sim_edge8",    0, 4'b0110, 1, 2'd3, 1, 1, 0);
    add("sim_rel",      0, 4'b1111, 7, 2'd0, 0, 0, 0);
    // Reset mid-debounce, then reset mid-hold.
    add("rd_pre",       0, 4'b1110, 4, 2'd0, 0, 0, 0);
    add("rd_rst",       1, 4'b1110, 1, 2'd0, 0, 0, 0);
    add("rd_wait",      0, 4'b1110, 6, 2'd0, 0, 0, 0);
    add("rd_press",     0, 4'b1110, 1, 2'd0, 1, 0, 1);
    add("rh_hold",      0, 4'b1110, 3, 2'd0, 1, 0, 0);
    add("rh_rst",       1, 4'b1110, 1, 2'd0, 0, 0, 0);
    add("rh_wait",      0, 4'b1110, 6, 2'd0, 0, 0, 0);
    add("rh_press",     0, 4'b1110, 1, 2'd0, 1, 0, 1);
    add("final_rel",    0, 4'b1111, 7, 2'd0, 0, 0, 0);

    for (int v = 0; v < tbl.size(); v++) begin
      apply(tbl[v].rst, tbl[v].btn_n, tbl[v].cycles);
      vectors++;
      if ({code, valid, multi, press} !== {tbl[v].code, tbl[v].valid, tbl[v].multi, tbl[v].press}) begin
        errors++;
        $display("FAIL vec %0d %s: got code=%0d valid=%b multi=%b press=%b, want code=%0d valid=%b multi=%b press=%b",
                 v, tbl[v].name, code, valid, multi, press,
                 tbl[v].code, tbl[v].valid, tbl[v].multi, tbl[v].press);
      end else begin
        $display("vec %0d %s: btn_n=%b x%0d code=%0d valid=%b multi=%b press=%b",
                 v, tbl[v].name, tbl[v].btn_n, tbl[v].cycles, code, valid, multi, press);
      end
    end

    // Random bursts: mix of short bounces and long holds, rare resets.
    for (int t = 0; t < 250; t++) begin
      rb = 4'($urandom);
      rr = ($urandom_range(0, 40) == 0);
      rn = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 14)) : int'($urandom_range(1, 5));
      apply(rr, rb, rn);
      $display("rand %0d: rst=%b btn_n=%b x%0d -> code=%0d valid=%b multi=%b press=%b",
               t, rr, rb, rn, code, valid, multi, press);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
